// File: rtl/pair_range_pkg.sv
// -----------------------------------------------------------------------------
// pair_range_pkg
// Shared definitions for the pair_range_gen producer:
//   - PR_WIDTH     : default datapath width (signed two's complement).
//   - pr_state_e   : generator FSM states (_state_done, _state_run).
//   - pr_range_ok  : combines signed-compare results into the in_range term,
//                    with an optional inclusive bound.
// -----------------------------------------------------------------------------
package pair_range_pkg;

    localparam int PR_WIDTH = 32;

    typedef enum logic {
        _state_done = 1'b0,
        _state_run  = 1'b1
    } pr_state_e;

    // The iterator is in range when it has not yet crossed the bound in the
    // direction of travel. A zero step matches neither direction, so the range
    // is empty. With an inclusive bound, landing exactly on the limit counts.
    function automatic logic pr_range_ok(
        input logic step_pos,
        input logic step_neg,
        input logic i_lt_lim,
        input logic i_eq_lim,
        input logic inclusive
    );
        logic i_gt_lim;
        i_gt_lim = !i_lt_lim && !i_eq_lim;
        return (step_pos && (i_lt_lim || (inclusive && i_eq_lim))) ||
               (step_neg && (i_gt_lim || (inclusive && i_eq_lim)));
    endfunction

endpackage

// File: rtl/pair_range_step.sv
// -----------------------------------------------------------------------------
// pair_range_step
// Combinational arithmetic for one iteration of the range generator.
// Ports:
//   i_i        : current iterator value (signed, WIDTH)
//   step_i     : latched step (signed, WIDTH)
//   limit_i    : latched bound (signed, WIDTH)
//   in_range_o : i_i has not crossed limit_i in the direction of step_i
//   next_i_o   : i_i + step_i truncated to WIDTH
//   ovf_o      : the WIDTH+1-bit sum does not fit in WIDTH bits
// Config macro: PAIR_RANGE_GEN_INCLUSIVE_EN makes the bound inclusive.
// -----------------------------------------------------------------------------
module pair_range_step
    import pair_range_pkg::*;
#(
    parameter int WIDTH = PR_WIDTH
) (
    input  logic signed [WIDTH-1:0] i_i,
    input  logic signed [WIDTH-1:0] step_i,
    input  logic signed [WIDTH-1:0] limit_i,
    output logic                    in_range_o,
    output logic signed [WIDTH-1:0] next_i_o,
    output logic                    ovf_o
);

`ifdef PAIR_RANGE_GEN_INCLUSIVE_EN
    localparam logic INCLUSIVE = 1'b1;
`else
    localparam logic INCLUSIVE = 1'b0;
`endif

    logic signed [WIDTH:0] sum;
    logic                  step_pos;
    logic                  step_neg;
    logic                  i_lt_lim;
    logic                  i_eq_lim;

    // Sign bits and a reduction OR avoid mixing the operand with a 32-bit
    // literal, which would otherwise change compare width/signedness.
    assign step_neg = step_i[WIDTH-1];
    assign step_pos = !step_i[WIDTH-1] && (|step_i);
    assign i_lt_lim = (i_i < limit_i);
    assign i_eq_lim = (i_i == limit_i);

    assign in_range_o = pr_range_ok(step_pos, step_neg, i_lt_lim, i_eq_lim, INCLUSIVE);

    // Sign-extend both operands by one bit; the sum overflows WIDTH exactly
    // when the two top bits of the widened result disagree.
    assign sum      = {i_i[WIDTH-1], i_i} + {step_i[WIDTH-1], step_i};
    assign next_i_o = sum[WIDTH-1:0];
    assign ovf_o    = sum[WIDTH] ^ sum[WIDTH-1];

endmodule

// File: rtl/pair_range_gen.sv
// -----------------------------------------------------------------------------
// pair_range_gen
// Ready/valid generator producer: on _start latches base/limit/step and yields
// tuples (_0 = i, _1 = n) for i in range(base, limit, step), n = 0-based index.
// Ports:
//   _clock  : clock, all state updates on posedge
//   _reset  : asynchronous active-low reset
//   _start  : capture base/limit/step and restart generation
//   base    : range start (signed, WIDTH)
//   limit   : range bound, exclusive by default (signed, WIDTH)
//   step    : increment (signed, WIDTH)
//   _ready  : caller accepts the current tuple
//   _valid  : _0/_1 hold an unconsumed tuple
//   _done   : level, high while idle/exhausted
//   _0      : current i
//   _1      : current index n
// Config macro: PAIR_RANGE_GEN_INCLUSIVE_EN (inclusive bound, see step module).
// -----------------------------------------------------------------------------
module pair_range_gen
    import pair_range_pkg::*;
#(
    parameter int WIDTH = PR_WIDTH
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    _start,
    input  logic signed [WIDTH-1:0] base,
    input  logic signed [WIDTH-1:0] limit,
    input  logic signed [WIDTH-1:0] step,
    input  logic                    _ready,
    output logic                    _valid,
    output logic                    _done,
    output logic signed [WIDTH-1:0] _0,
    output logic signed [WIDTH-1:0] _1
);

    pr_state_e               state_q;
    logic                    valid_q;
    logic                    done_q;
    logic signed [WIDTH-1:0] out0_q;
    logic signed [WIDTH-1:0] out1_q;
    logic signed [WIDTH-1:0] i_q;
    logic signed [WIDTH-1:0] n_q;
    logic signed [WIDTH-1:0] limit_q;
    logic signed [WIDTH-1:0] step_q;
    logic                    ovf_q;

    logic                    in_range;
    logic signed [WIDTH-1:0] next_i;
    logic                    ovf;
    logic signed [WIDTH-1:0] n_d;
    logic                    advance;

    pair_range_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_i       (i_q),
        .step_i    (step_q),
        .limit_i   (limit_q),
        .in_range_o(in_range),
        .next_i_o  (next_i),
        .ovf_o     (ovf)
    );

    assign n_d     = n_q + WIDTH'(1);
    // Move on when the held tuple is being taken or there is nothing held.
    assign advance = _ready || !valid_q;

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state_q <= _state_done;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            out0_q  <= '0;
            out1_q  <= '0;
            i_q     <= '0;
            n_q     <= '0;
            limit_q <= '0;
            step_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (_ready) begin
                valid_q <= 1'b0;
            end

            if (_start) begin
                // Restart drops any pending tuple; a same-cycle _ready is
                // not treated as consuming it.
                limit_q <= limit;
                step_q  <= step;
                i_q     <= base;
                n_q     <= '0;
                valid_q <= 1'b0;
                ovf_q   <= 1'b0;
                state_q <= _state_run;
            end else if (advance) begin
                case (state_q)
                    _state_run: begin
                        if (in_range && !ovf_q) begin
                            out0_q  <= i_q;
                            out1_q  <= n_q;
                            valid_q <= 1'b1;
                            n_q     <= n_d;
                            i_q     <= next_i;
                            // A wrapped successor must never be emitted, so
                            // this tuple becomes the last one.
                            if (ovf) begin
                                ovf_q <= 1'b1;
                            end
                        end else begin
                            state_q <= _state_done;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= _state_done;
                        done_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign _valid = valid_q;
    assign _done  = done_q;
    assign _0     = out0_q;
    assign _1     = out1_q;

endmodule

// File: tb/tb_pair_range_gen.sv
// -----------------------------------------------------------------------------
// tb_pair_range_gen
// Directed testbench for pair_range_gen with hand-computed expected tuples.
// -----------------------------------------------------------------------------
module tb_pair_range_gen;

`ifdef PAIR_RANGE_GEN_INCLUSIVE_EN
    localparam bit INCL = 1'b1;
`else
    localparam bit INCL = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               ready;
    logic signed [31:0] base;
    logic signed [31:0] limit;
    logic signed [31:0] step;
    logic               valid;
    logic               done;
    logic signed [31:0] o0;
    logic signed [31:0] o1;

    int n_tests = 0;
    int n_fail  = 0;
    int acc     = 0;

    pair_range_gen #(
        .WIDTH(32)
    ) dut (
        ._clock(clk),
        ._reset(rst_n),
        ._start(start),
        .base  (base),
        .limit (limit),
        .step  (step),
        ._ready(ready),
        ._valid(valid),
        ._done (done),
        ._0    (o0),
        ._1    (o1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Accepted tuples: valid and ready on an edge that is not a restart.
    always @(posedge clk) begin
        if (rst_n && valid && ready && !start) begin
            acc <= acc + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic signed [31:0] b, input logic signed [31:0] l,
                             input logic signed [31:0] s, input logic r);
        start = 1'b1;
        base  = b;
        limit = l;
        step  = s;
        ready = r;
        tick();
        start = 1'b0;
        check("start_valid", valid, 0);
        check("start_done", done, 0);
    endtask

    initial begin
        int nexp;
        rst_n = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        base  = '0;
        limit = '0;
        step  = '0;
        #1 rst_n = 1'b0;
        #3;
        check("rst_valid", valid, 0);
        check("rst_done", done, 1);
        check("rst_o0", o0, 0);
        check("rst_o1", o1, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_done", done, 1);
        check("idle_valid", valid, 0);

        // (0,10,2), ready held high: one tuple per cycle.
        nexp = INCL ? 6 : 5;
        acc  = 0;
        start_run(0, 10, 2, 1'b1);
        for (int k = 0; k < nexp; k++) begin
            tick();
            check("up_valid", valid, 1);
            check("up_done", done, 0);
            check("up_i", o0, 2 * k);
            check("up_n", o1, k);
        end
        tick();
        check("up_end_valid", valid, 0);
        check("up_end_done", done, 1);
        check("up_accepts", acc, nexp);

        // (10,0,-3), ready toggling; tuples hold while ready is low.
        acc = 0;
        start_run(10, 0, -3, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            check("dn_valid", valid, 1);
            check("dn_i", o0, 10 - 3 * k);
            check("dn_n", o1, k);
            ready = 1'b0;
            tick();
            check("dn_hold_valid", valid, 1);
            check("dn_hold_i", o0, 10 - 3 * k);
            check("dn_hold_n", o1, k);
            ready = 1'b1;
            tick();
        end
        check("dn_end_valid", valid, 0);
        check("dn_end_done", done, 1);
        check("dn_accepts", acc, 4);

        // base == limit: empty unless the bound is inclusive.
        start_run(5, 5, 1, 1'b1);
        tick();
        check("eq_valid", valid, INCL);
        check("eq_done", done, !INCL);

        // step == 0: always empty.
        start_run(0, 10, 0, 1'b1);
        tick();
        check("z_valid", valid, 0);
        check("z_done", done, 1);

        // Wrong-sign step: empty.
        start_run(0, 10, -1, 1'b1);
        tick();
        check("ws_valid", valid, 0);
        check("ws_done", done, 1);

        // Overflow stop near the positive limit.
        start_run(32'sd2147483640, 32'sd2147483647, 5, 1'b1);
        tick();
        check("ov0_valid", valid, 1);
        check("ov0_i", o0, 32'sd2147483640);
        check("ov0_n", o1, 0);
        tick();
        check("ov1_valid", valid, 1);
        check("ov1_i", o0, 32'sd2147483645);
        check("ov1_n", o1, 1);
        tick();
        check("ov_end_valid", valid, 0);
        check("ov_end_done", done, 1);

        // Restart while tuple i=3 is pending.
        start_run(0, 100, 1, 1'b1);
        repeat (4) tick();
        check("rs_pend_i", o0, 3);
        ready = 1'b0;
        tick();
        check("rs_hold_i", o0, 3);
        check("rs_hold_valid", valid, 1);
        acc = 0;
        start_run(0, 100, 1, 1'b1);
        tick();
        check("rs_valid", valid, 1);
        check("rs_i", o0, 0);
        check("rs_n", o1, 0);
        check("rs_accepts", acc, 0);

        // Async reset mid-run, no clock edge needed.
        tick();
        tick();
        check("ar_pre_valid", valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", valid, 0);
        check("ar_done", done, 1);
        check("ar_i", o0, 0);
        #1 rst_n = 1'b1;
        tick();
        tick();
        check("ar_idle_valid", valid, 0);
        check("ar_idle_done", done, 1);
        start_run(0, 10, 2, 1'b1);
        tick();
        check("ar_new_valid", valid, 1);
        check("ar_new_i", o0, 0);
        check("ar_new_n", o1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
